// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-RAM arbiter: port identity and the RAM request bundle.
// Pure declarations; no latency, no backpressure.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_WIDTH = 10;
  localparam int DMEM_DATA_WIDTH = 32;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  typedef struct packed {
    logic                       we;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [DMEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_A) ? OWNER_B : OWNER_A;
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Round-robin grant with bounded burst between ports A and B; grant is combinational (0 cycles).
// A losing requester simply sees no grant and must hold its request.
module dmem_arb_rr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   a_req,
  input  logic   b_req,
  output logic   a_gnt,
  output logic   b_gnt,
  output owner_t gnt_port
);

  owner_t     owner_q, owner_d;
  logic [3:0] burst_q, burst_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_q <= OWNER_A;
      burst_q <= 4'd0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    gnt_port = owner_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    if (!RST) begin
      if (a_req && b_req) begin
        // Only contended grants count toward the burst limit.
        gnt_port = (burst_q == 4'(MAX_BURST)) ? other_owner(owner_q) : owner_q;
        owner_d  = gnt_port;
        burst_d  = (gnt_port == owner_q) ? burst_q + 4'd1 : 4'd1;
      end else if (a_req) begin
        gnt_port = OWNER_A;
        owner_d  = OWNER_A;
        burst_d  = 4'd0;
      end else if (b_req) begin
        gnt_port = OWNER_B;
        owner_d  = OWNER_B;
        burst_d  = 4'd0;
      end else begin
        burst_d  = 4'd0;
      end
      a_gnt = (a_req || b_req) && (gnt_port == OWNER_A);
      b_gnt = (a_req || b_req) && (gnt_port == OWNER_B);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port sync-read data RAM; read data returns 1 cycle after grant.
// Ungranted masters hold their request; reads are fully pipelined, one transfer per cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  owner_t                gnt_port;
  owner_t                rsp_tag;
  logic                  rsp_valid;
  logic                  any_gnt;
  mem_req_t              a_op, b_op, sel_op;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [DATA_WIDTH-1:0] last_wdata_q;

  dmem_arb_rr #(
    .MAX_BURST(MAX_BURST)
  ) u_rr (
    .CLK     (CLK),
    .RST     (RST),
    .a_req   (a_req),
    .b_req   (b_req),
    .a_gnt   (a_gnt),
    .b_gnt   (b_gnt),
    .gnt_port(gnt_port)
  );

  assign a_op    = '{we: a_we, addr: a_addr, wdata: a_wdata};
  assign b_op    = '{we: b_we, addr: b_addr, wdata: b_wdata};
  assign sel_op  = b_gnt ? b_op : a_op;
  assign any_gnt = a_gnt | b_gnt;

  // Idle cycles replay the last granted address/data so the RAM inputs never toggle spuriously.
  assign mem_we    = any_gnt & sel_op.we;
  assign mem_addr  = any_gnt ? sel_op.addr  : last_addr_q;
  assign mem_wdata = any_gnt ? sel_op.wdata : last_wdata_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      rsp_valid    <= 1'b0;
      rsp_tag      <= OWNER_A;
    end else begin
      rsp_valid <= any_gnt & ~sel_op.we;
      if (any_gnt) begin
        last_addr_q  <= sel_op.addr;
        last_wdata_q <= sel_op.wdata;
        rsp_tag      <= gnt_port;
      end
    end
  end

  // A response whose cycle coincides with reset is dropped.
  assign a_rvalid = rsp_valid & ~RST & (rsp_tag == OWNER_A);
  assign b_rvalid = rsp_valid & ~RST & (rsp_tag == OWNER_B);
  assign a_rdata  = a_rvalid ? mem_rdata : '0;
  assign b_rdata  = b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RST(RST),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Write-first single-port RAM with synchronous read.
  logic [DW-1:0] ram [0:1023] = '{default: '0};
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=\"%s\" expected=\"%s\"", nm, act, exp);
    end
  endtask

  // Request queues per master; head is presented until granted.
  mem_req_t qa[$];
  mem_req_t qb[$];
  bit       took_a = 0, took_b = 0;
  bit       rnd_mode = 0;

  task automatic push_a(input bit we, input int addr, input logic [DW-1:0] d);
    qa.push_back('{we: we, addr: AW'(addr), wdata: d});
  endtask
  task automatic push_b(input bit we, input int addr, input logic [DW-1:0] d);
    qb.push_back('{we: we, addr: AW'(addr), wdata: d});
  endtask

  function automatic mem_req_t rand_op();
    mem_req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = AW'($urandom_range(0, 7));
    r.wdata = $urandom;
    return r;
  endfunction

  initial begin
    bit wd;
    forever begin
      @(posedge CLK);
      #1;
      wd = 0;
      if (took_a) qa.delete(0);
      else if (rnd_mode && qa.size() > 0 && $urandom_range(0, 15) == 0) begin qa.delete(0); wd = 1; end
      if (rnd_mode && !wd && qa.size() == 0 && $urandom_range(0, 2) != 0) qa.push_back(rand_op());
      a_req = !wd && qa.size() > 0;
      if (a_req) begin a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata; end
      wd = 0;
      if (took_b) qb.delete(0);
      else if (rnd_mode && qb.size() > 0 && $urandom_range(0, 15) == 0) begin qb.delete(0); wd = 1; end
      if (rnd_mode && !wd && qb.size() == 0 && $urandom_range(0, 2) != 0) qb.push_back(rand_op());
      b_req = !wd && qb.size() > 0;
      if (b_req) begin b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata; end
    end
  end

  // Behavioural model: who owns the RAM, how long the current contended run is,
  // what the memory holds, and which read answer is due next cycle.
  bit            own_b = 0;
  int            run = 0;
  bit            pv = 0, pb = 0;
  logic [DW-1:0] pdata = '0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [DW-1:0] ref_mem [0:1023] = '{default: '0};

  typedef struct { bit b; logic [DW-1:0] d; int c; } rsp_t;
  string glog = "";
  rsp_t  rlog[$];
  int    we_cnt = 0;

  always @(negedge CLK) begin : compare
    bit ga, gb, xwe, era, erb;
    logic [AW-1:0] xa;
    logic [DW-1:0] xd;
    cyc++;
    ga = 0;
    gb = 0;
    if (!RST) begin
      if (a_req && b_req) begin
        gb = (run >= MB) ? !own_b : own_b;
        ga = !gb;
      end else begin
        ga = a_req;
        gb = b_req;
      end
    end
    xwe = gb ? b_we : a_we;
    xa  = gb ? b_addr : a_addr;
    xd  = gb ? b_wdata : a_wdata;
    chk("a_gnt", 32'(a_gnt), 32'(ga));
    chk("b_gnt", 32'(b_gnt), 32'(gb));
    chk("mem_we", 32'(mem_we), 32'((ga | gb) & xwe));
    chk("mem_addr", 32'(mem_addr), 32'((ga | gb) ? xa : last_addr));
    chk("mem_wdata", mem_wdata, (ga | gb) ? xd : last_wdata);
    era = pv && !pb && !RST;
    erb = pv && pb && !RST;
    chk("a_rvalid", 32'(a_rvalid), 32'(era));
    chk("b_rvalid", 32'(b_rvalid), 32'(erb));
    if (era) chk("a_rdata", a_rdata, pdata);
    if (erb) chk("b_rdata", b_rdata, pdata);

    took_a = a_req && a_gnt;
    took_b = b_req && b_gnt;
    if (a_gnt) glog = {glog, "A"};
    else if (b_gnt) glog = {glog, "B"};
    if (a_rvalid) rlog.push_back('{b: 1'b0, d: a_rdata, c: cyc});
    if (b_rvalid) rlog.push_back('{b: 1'b1, d: b_rdata, c: cyc});
    if (mem_we) we_cnt++;

    if (RST) begin
      own_b = 0; run = 0; pv = 0; last_addr = '0; last_wdata = '0;
    end else begin
      pv = 0;
      if (ga | gb) begin
        if (xwe) ref_mem[xa] = xd;
        else begin pv = 1; pb = gb; pdata = ref_mem[xa]; end
        last_addr  = xa;
        last_wdata = xd;
      end
      if (a_req && b_req) begin
        run   = (gb == own_b) ? run + 1 : 1;
        own_b = gb;
      end else begin
        run = 0;
        if (ga | gb) own_b = gb;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout queued_a=%0d queued_b=%0d required=0", qa.size(), qb.size());
    end
    repeat (3) @(posedge CLK);
    #2;
  endtask

  function automatic string rsp_ports(input int from);
    string s;
    s = "";
    for (int i = from; i < rlog.size(); i++) s = {s, rlog[i].b ? "B" : "A"};
    return s;
  endfunction

  initial begin
    int g0, r0, w0;

    // Reset with both masters requesting.
    push_a(0, 0, '0);
    push_b(0, 0, '0);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_b_gnt", 32'(b_gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid", 32'(a_rvalid | b_rvalid), 0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    @(negedge CLK);
    #1;
    chk("post_rst_a_gnt", 32'(a_gnt), 1);
    chk("post_rst_b_gnt", 32'(b_gnt), 0);
    wait_idle();

    // Port A alone: write then read back.
    g0 = glog.len(); r0 = rlog.size(); w0 = we_cnt;
    push_a(1, 3, 32'hDEADBEEF);
    push_a(0, 3, '0);
    wait_idle();
    chk("t2_writes", 32'(we_cnt - w0), 1);
    chk_s("t2_grants", glog.substr(g0, glog.len() - 1), "AA");
    chk_s("t2_rsp_ports", rsp_ports(r0), "A");
    if (rlog.size() > r0) chk("t2_rdata", rlog[r0].d, 32'hDEADBEEF);

    // Continuous contention: bursts of MAX_BURST alternate.
    g0 = glog.len(); r0 = rlog.size();
    for (int i = 0; i < 12; i++) begin
      push_a(0, i, '0);
      push_b(0, 16 + i, '0);
    end
    wait_idle();
    chk_s("t3_grants", glog.substr(g0, glog.len() - 1), "AAAABBBBAAAABBBBAAAABBBB");
    chk_s("t3_rsp_ports", rsp_ports(r0), "AAAABBBBAAAABBBBAAAABBBB");

    // Preload through A, then pipelined reads from B.
    for (int i = 0; i < 3; i++) push_a(1, i, 32'h10 + i);
    wait_idle();
    r0 = rlog.size();
    for (int i = 0; i < 3; i++) push_b(0, i, '0);
    wait_idle();
    chk_s("t4_rsp_ports", rsp_ports(r0), "BBB");
    if (rlog.size() - r0 == 3) begin
      for (int i = 0; i < 3; i++) chk("t4_rdata", rlog[r0 + i].d, 32'h10 + i);
      chk("t4_back_to_back", 32'(rlog[r0 + 2].c - rlog[r0].c), 2);
    end

    // Cross-port read-after-write on consecutive cycles.
    g0 = glog.len(); r0 = rlog.size();
    @(posedge CLK);
    #2;
    push_a(1, 5, 32'h55AA55AA);
    @(posedge CLK);
    #2;
    push_b(0, 5, '0);
    wait_idle();
    chk_s("t5_grants", glog.substr(g0, glog.len() - 1), "AB");
    chk_s("t5_rsp_ports", rsp_ports(r0), "B");
    if (rlog.size() > r0) chk("t5_rdata", rlog[r0].d, 32'h55AA55AA);

    // Reset right after a granted B read: response dropped, owner back to A.
    r0 = rlog.size();
    @(posedge CLK);
    #2;
    push_b(0, 7, '0);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk("t6_dropped_rsp", 32'(rlog.size() - r0), 0);
    g0 = glog.len();
    push_a(0, 1, '0);
    push_b(0, 2, '0);
    wait_idle();
    chk_s("t6_first_grant", glog.substr(g0, g0), "A");

    // Randomized traffic with withdrawals and occasional reset pulses.
    rnd_mode = 1;
    repeat (3000) begin
      @(posedge CLK);
      #2;
      RST = ($urandom_range(0, 199) == 0);
    end
    RST = 1'b0;
    rnd_mode = 0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
